// File: rtl/if_slice.sv
// -----------------------------------------------------------------------------
// if_slice -- instruction fetch stage with IF/ID pipeline register
//
// Fetches one 16-bit instruction word per request from a variable-latency
// instruction memory and presents it to decode through the IF/ID register.
// The PC is a 16-bit word address that normally advances by one (wrapping).
//
// States:
//   FETCH : request outstanding at imem_addr (= PC), waiting for imem_valid
//   HOLD  : response captured while decode was stalled; waiting for release
//   KILL  : a redirect arrived while a response was still in flight; that
//           response is dropped before fetching from the new PC
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-low reset
//   stall        decode stalled: hold PC and IF/ID
//   flush        load a bubble (instr 16'hF000, valid 0) into IF/ID
//   redirect     later stage resolved a taken branch/call/return
//   redirect_pc  word address of the redirect target
//   imem_req     fetch request for imem_addr
//   imem_addr    word address being fetched (the PC register)
//   imem_rdata   instruction word, qualified by imem_valid
//   imem_valid   single-cycle response strobe, one per request
//   PC_inc       IF/ID: fetched PC + 1
//   instr        IF/ID: fetched instruction or bubble 16'hF000
//   valid        IF/ID: holds a real instruction
//
// Optional feature (macro IF_CALL_EARLY_EN): an accepted instruction with
// opcode 4'hD redirects fetch immediately to {PC+1[15:12], instr[11:0]}.
// Without the macro the next PC is always PC+1.
// -----------------------------------------------------------------------------
module if_slice (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] PC_inc,
    output logic [15:0] instr,
    output logic        valid
);

    localparam logic [15:0] BUBBLE = 16'hF000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] hold_buf, hold_buf_nxt;
    logic [15:0] pc_plus1;
    logic [15:0] load_word;
    logic [15:0] advance_pc;
    logic        accept;

    assign imem_addr = pc;

    always_comb begin
        pc_plus1  = pc + 16'd1;
        // The word entering IF/ID comes from the buffer when leaving HOLD,
        // otherwise straight from the memory response.
        load_word = (state == HOLD) ? hold_buf : imem_rdata;
`ifdef IF_CALL_EARLY_EN
        advance_pc = (load_word[15:12] == 4'hD) ? {pc_plus1[15:12], load_word[11:0]}
                                                : pc_plus1;
`else
        advance_pc = pc_plus1;
`endif

        state_nxt    = state;
        pc_nxt       = pc;
        hold_buf_nxt = hold_buf;
        accept       = 1'b0;
        imem_req     = 1'b0;

        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    // A response arriving this very cycle closes the request;
                    // otherwise one is still in flight and must be dropped.
                    state_nxt = imem_valid ? FETCH : KILL;
                end else if (imem_valid) begin
                    if (stall) begin
                        hold_buf_nxt = imem_rdata;
                        state_nxt    = HOLD;
                    end else begin
                        accept = 1'b1;
                        pc_nxt = advance_pc;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    accept    = 1'b1;
                    pc_nxt    = advance_pc;
                    state_nxt = FETCH;
                end
            end
            KILL: begin
                // Further redirects only retarget the PC; the stale response
                // still has to be swallowed.
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                if (imem_valid) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            pc       <= 16'h0000;
            hold_buf <= 16'h0000;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    // IF/ID register: flush beats both stall and a same-cycle accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_inc <= 16'h0000;
            instr  <= BUBBLE;
            valid  <= 1'b0;
        end else if (flush) begin
            instr  <= BUBBLE;
            valid  <= 1'b0;
        end else if (accept) begin
            PC_inc <= pc_plus1;
            instr  <= load_word;
            valid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_slice.sv
module tb_if_slice;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] PC_inc;
    logic [15:0] instr;
    logic        valid;

    always #5 clk = ~clk;

    if_slice dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .PC_inc      (PC_inc),
        .instr       (instr),
        .valid       (valid)
    );

    // ---------------- instruction memory (latency lat_cur cycles) ----------
    logic [15:0] mem_arr [0:65535];
    logic        busy;
    int          age;
    int          lat_cur;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [15:0] mem_addr_q;

    always_comb begin
        imem_valid = rst && (busy || imem_req) && ((age + 1) == lat_cur);
        imem_rdata = mem_arr[busy ? mem_addr_q : imem_addr];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            age     <= 0;
            lat_cur <= 1;
        end else if (imem_valid) begin
            busy    <= 1'b0;
            age     <= 0;
            lat_cur <= int'($urandom_range(lat_hi, lat_lo));
        end else if (busy || imem_req) begin
            if (!busy) mem_addr_q <= imem_addr;
            busy <= 1'b1;
            age  <= age + 1;
        end
    end

    // ---------------- reference model -------------------------------------
    logic [15:0] m_pc, m_pcinc, m_instr, m_held_word;
    logic        m_valid, m_held, m_drop;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] target(input logic [15:0] pc1, input logic [15:0] w);
`ifdef IF_CALL_EARLY_EN
        if (w[15:12] == 4'hD) return {pc1[15:12], w[11:0]};
`endif
        return pc1;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_pcinc = 16'h0000; m_instr = 16'hF000;
        m_valid = 1'b0; m_held = 1'b0; m_drop = 1'b0; m_held_word = 16'h0000;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d);
        logic [15:0] pc1;
        logic [15:0] w;
        logic        take;
        pc1  = m_pc + 16'd1;
        w    = d;
        take = 1'b0;
        if (m_drop) begin
            if (redirect) m_pc = redirect_pc;
            if (v) m_drop = 1'b0;
        end else if (m_held) begin
            if (redirect) begin
                m_pc = redirect_pc; m_held = 1'b0;
            end else if (!stall) begin
                take = 1'b1; w = m_held_word; m_held = 1'b0;
            end
        end else begin
            if (redirect) begin
                m_pc = redirect_pc; m_drop = !v;
            end else if (v) begin
                if (stall) begin
                    m_held = 1'b1; m_held_word = d;
                end else begin
                    take = 1'b1;
                end
            end
        end
        if (take) m_pc = target(pc1, w);
        if (flush) begin
            m_instr = 16'hF000; m_valid = 1'b0;
        end else if (take) begin
            m_pcinc = pc1; m_instr = w; m_valid = 1'b1;
        end
    endtask

    // One clock: inputs already driven at the preceding negedge.
    task automatic cycle();
        logic        v;
        logic [15:0] d;
        #1;
        chk("req",    16'(imem_req), 16'(!m_held && !m_drop));
        chk("addr",   imem_addr, m_pc);
        chk("pc_inc", PC_inc,    m_pcinc);
        chk("instr",  instr,     m_instr);
        chk("valid",  16'(valid), 16'(m_valid));
        if (!valid) chk("bubble_only", instr, 16'hF000);
        v = imem_valid;
        d = imem_rdata;
        @(posedge clk);
        if (rst) model_step(v, d);
        else     model_reset();
        @(negedge clk);
    endtask

    task automatic wait_fetch(input logic [15:0] a);
        int n;
        n = 0;
        while (!(imem_req && imem_addr == a) && n < 20) begin
            cycle();
            n++;
        end
        chk("wait_fetch_req",  16'(imem_req), 16'd1);
        chk("wait_fetch_addr", imem_addr, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},   imem_addr, 16'h0000);
        chk({tag, "_pcinc"},  PC_inc,    16'h0000);
        chk({tag, "_instr"},  instr,     16'hF000);
        chk({tag, "_valid"},  16'(valid), 16'd0);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] exp_call;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (i < 32768 && w[15:12] == 4'hD) w[15:12] = 4'h1;
            mem_arr[i] = w;
        end
        mem_arr[16'h0010] = 16'h1234;
        mem_arr[16'h4007] = 16'hD123;
        model_reset();

        // reset state
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        cycle();
        rst = 1'b1;
        chk("r025_req",  16'(imem_req), 16'd1);
        chk("r025_addr", imem_addr, 16'h0000);

        // single-cycle memory streaming
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("r028_addr",  imem_addr, 16'(i));
            chk("r028_pcinc", PC_inc,    16'(i));
            chk("r028_valid", 16'(valid), 16'd1);
        end

        // 3-cycle latency at 0x0005
        cycle();
        lat_lo = 3; lat_hi = 3;
        cycle();
        for (int k = 0; k < 3; k++) begin
            chk("r029_req",  16'(imem_req), 16'd1);
            chk("r029_addr", imem_addr, 16'h0005);
            if (k > 0) chk("r029_hold_pcinc", PC_inc, 16'h0005);
            cycle();
        end
        chk("r029_pcinc", PC_inc, 16'h0006);

        // stall capture at 0x0010
        lat_lo = 1; lat_hi = 1;
        redirect = 1'b1; redirect_pc = 16'h0010;
        cycle();
        redirect = 1'b0;
        wait_fetch(16'h0010);
        stall = 1'b1;
        cycle();
        chk("r030_hold_req",   16'(imem_req), 16'd0);
        chk("r030_hold_pcinc", PC_inc, 16'h0006);
        cycle();
        chk("r030_hold_instr", instr, mem_arr[16'h0005]);
        lat_lo = 3; lat_hi = 3;
        stall = 1'b0;
        cycle();
        chk("r030_instr", instr,     16'h1234);
        chk("r030_pcinc", PC_inc,    16'h0011);
        chk("r030_addr",  imem_addr, 16'h0011);

        // redirect + flush mid-wait
        cycle();
        redirect = 1'b1; flush = 1'b1; redirect_pc = 16'h0100;
        cycle();
        redirect = 1'b0; flush = 1'b0;
        chk("r031_instr", instr, 16'hF000);
        chk("r031_valid", 16'(valid), 16'd0);
        lat_lo = 1; lat_hi = 1;
        wait_fetch(16'h0100);
        chk("r031_still_bubble", 16'(valid), 16'd0);

        // call opcode at 0x4007
        redirect = 1'b1; redirect_pc = 16'h4007;
        cycle();
        redirect = 1'b0;
        wait_fetch(16'h4007);
        cycle();
`ifdef IF_CALL_EARLY_EN
        exp_call = 16'h4123;
`else
        exp_call = 16'h4008;
`endif
        chk("r032_instr", instr,     16'hD123);
        chk("r032_pcinc", PC_inc,    16'h4008);
        chk("r032_addr",  imem_addr, exp_call);

        // reset during HOLD at 0x0020
        redirect = 1'b1; redirect_pc = 16'h0020;
        cycle();
        redirect = 1'b0;
        wait_fetch(16'h0020);
        stall = 1'b1;
        cycle();
        chk("r033_in_hold", 16'(imem_req), 16'd0);
        rst = 1'b0;
        #1;
        check_reset_outputs("r033");
        chk("r033_req", 16'(imem_req), 16'd1);
        model_reset();
        stall = 1'b0;
        cycle();
        rst = 1'b1;
        chk("r033_restart", imem_addr, 16'h0000);
        cycle();
        chk("r033_next", imem_addr, 16'h0001);

        // randomized traffic
        lat_lo = 1; lat_hi = 4;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom % 10) < 3;
            flush       = ($urandom % 10) == 0;
            redirect    = ($urandom % 16) == 0;
            redirect_pc = 16'($urandom);
            if (($urandom % 400) == 0) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("rand_reset");
                model_reset();
                cycle();
                rst = 1'b1;
            end else begin
                cycle();
            end
        end
        stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_slice.md
IF_SLICE -- requirements
Module: if_slice

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 stall  input  1  decode stage stalled: hold PC and the IF/ID register.
REQ-004 flush  input  1  replace the IF/ID contents with a bubble on the next edge.
REQ-005 redirect  input  1  a later stage has resolved a taken branch, call or return.
REQ-006 redirect_pc  input  16  word address of the redirect target.
REQ-007 imem_req  output  1  fetch request for imem_addr.
REQ-008 imem_addr  output  16  word address being fetched; equals the PC register.
REQ-009 imem_rdata  input  16  instruction word; valid only when imem_valid=1.
REQ-010 imem_valid  input  1  one-cycle response; exactly one response per request, after 1..N cycles.
REQ-011 PC_inc  output  16  IF/ID register: fetched PC+1.
REQ-012 instr  output  16  IF/ID register: fetched instruction, or bubble 16'hF000.
REQ-013 valid  output  1  IF/ID register holds a real instruction.

Function
REQ-014 States SHALL be FETCH, HOLD and KILL; PC is a 16-bit word address and increments by 1, wrapping 16'hFFFF->16'h0000.
REQ-015 FETCH: imem_req=1; imem_addr and the PC register SHALL stay stable until imem_valid arrives.
REQ-016 FETCH, imem_valid=1, stall=0, redirect=0: IF/ID <= {PC+1, imem_rdata, valid=1}; PC <= next PC; remain in FETCH (1-cycle latency when memory is single-cycle).
REQ-017 FETCH, imem_valid=1, stall=1, redirect=0: capture imem_rdata into the holding buffer; go to HOLD; PC unchanged.
REQ-018 HOLD: imem_req=0; when stall falls, write the buffer into IF/ID, advance PC, and go to FETCH.
REQ-019 redirect=1 in any state: PC <= redirect_pc; any captured or arriving instruction is discarded.
REQ-019a Next state after a redirect SHALL be FETCH if no response is outstanding, otherwise KILL.
REQ-020 KILL: imem_req=0; the first imem_valid SHALL be discarded, then the block goes to FETCH at the new PC.
REQ-020a A redirect received while in KILL SHALL overwrite the PC only.
REQ-021 flush=1 SHALL load the bubble {PC_inc unchanged, 16'hF000, valid=0} into IF/ID, overriding both stall and a same-cycle accept.
REQ-022 stall=1 without flush SHALL hold IF/ID unchanged; PC priority SHALL be rst > redirect > stall > advance.
REQ-023 The bubble opcode 4'hF SHALL be the only value driven on instr while valid=0.

Reset
REQ-024 On rst low, immediately: PC=16'h0000, state=FETCH, PC_inc=16'h0000, instr=16'hF000, valid=0, holding buffer cleared.
REQ-025 After rst rises, imem_req=1 with imem_addr=16'h0000 on the first edge.
REQ-025a Reset asserted mid-wait SHALL abandon the outstanding request; the memory is reset by the same signal.

Configuration
REQ-026 Macro IF_CALL_EARLY_EN.
REQ-026a When IF_CALL_EARLY_EN is defined: an accepted instruction with opcode 4'hD SHALL set next PC to {PC+1[15:12], instr[11:0]}, with no bubble.
REQ-026b When IF_CALL_EARLY_EN is defined, a redirect in the same cycle SHALL still take priority over the early call target.
REQ-027 When IF_CALL_EARLY_EN is undefined: next PC is always PC+1, and the call is resolved by a later stage via redirect.

Verification
REQ-028 Single-cycle memory, reset release, no stall: imem_addr 0,1,2,3 on consecutive cycles; PC_inc 1,2,3 with valid=1 from cycle 2.
REQ-029 3-cycle memory latency: imem_req held and imem_addr=16'h0005 stable for 3 cycles; IF/ID loads once with PC_inc=16'h0006.
REQ-030 Response at PC=16'h0010 with stall=1 for 2 cycles: HOLD entered and IF/ID unchanged; on release instr=the captured word, PC_inc=16'h0011, next fetch at 16'h0011.
REQ-031 Redirect to 16'h0100 with flush, mid-wait on a 3-cycle memory: the stale response is discarded, instr=16'hF000 with valid=0, and the next request goes to 16'h0100.
REQ-032 With IF_CALL_EARLY_EN, instr 16'hD123 fetched at PC=16'h4007: next imem_addr=16'h4123 with no bubble; without the macro, next imem_addr=16'h4008.
REQ-033 rst low during HOLD at PC=16'h0020: all outputs take their reset values immediately; fetch restarts at 16'h0000.
